nco_sweep_ctrl: RTL and testbench

- Frequency-sweep sequencer for the `nco` core.
- Drives `nco`'s frequency word, phase offset and enable so the NCO steps from a start to a stop frequency, holding each step for a programmable dwell.
- Configuration is loaded through a valid/ready handshake.
- A sweep is launched by `go` and ends with a one-cycle `done` pulse, or stops early on `abort`.

---
 rtl/nco_sweep_ctrl.sv | 168 ++++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer driving an NCO's frequency word, phase offset and enable.
// Optional triangle (up-and-back) sweep when NCO_SWEEP_TRI_EN is defined (adds cfg_tri).
module nco_sweep_ctrl #(
  parameter int FW = 10,
  parameter int PW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [FW-1:0] cfg_start,
  input  logic [FW-1:0] cfg_stop,
  input  logic [FW-1:0] cfg_step,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [PW-1:0] cfg_phase,
  input  logic          cfg_loop,
`ifdef NCO_SWEEP_TRI_EN
  input  logic          cfg_tri,
`endif
  input  logic          go,
  input  logic          abort,
  output logic [FW-1:0] freq_word,
  output logic [PW-1:0] phase_off,
  output logic          nco_en,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state, state_nx;
  logic [FW-1:0] freq_nx;
  logic [PW-1:0] phase_nx;
  logic [DW-1:0] cnt, cnt_nx;
  logic [FW-1:0] sh_start, sh_start_nx, sh_stop, sh_stop_nx, sh_step, sh_step_nx;
  logic [DW-1:0] sh_dwell, sh_dwell_nx;
  logic [PW-1:0] sh_phase, sh_phase_nx;
  logic          sh_loop, sh_loop_nx;
  logic          sh_tri, sh_tri_nx;
  logic          leg_back, leg_back_nx;
  logic          accept, fwd_up, tri_eff;
  logic [FW-1:0] target;

  // Move one step from cur toward tgt, clamping at tgt; never wraps.
  function automatic logic [FW-1:0] step_toward(input logic [FW-1:0] cur, input logic [FW-1:0] tgt,
                                                input logic [FW-1:0] stp, input logic up);
    logic [FW:0] sum;
    logic [FW:0] diff;
    sum  = {1'b0, cur} + {1'b0, stp};
    diff = {1'b0, cur} - {1'b0, stp};
    if (stp == '0)
      return tgt;
    else if (up)
      return (sum >= {1'b0, tgt}) ? tgt : sum[FW-1:0];
    else
      return (diff[FW] || diff[FW-1:0] <= tgt) ? tgt : diff[FW-1:0];
  endfunction

  assign accept    = cfg_valid && (state == S_IDLE);
  assign fwd_up    = (sh_start <= sh_stop);
  // A degenerate triangle (start == stop) behaves as a plain single dwell.
  assign tri_eff   = sh_tri && (sh_start != sh_stop);
  assign target    = leg_back ? sh_start : sh_stop;
  assign cfg_ready = (state == S_IDLE);
  assign nco_en    = (state == S_RUN);
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);

  always_comb begin
    state_nx    = state;
    freq_nx     = freq_word;
    phase_nx    = phase_off;
    cnt_nx      = cnt;
    leg_back_nx = leg_back;
    sh_start_nx = sh_start;
    sh_stop_nx  = sh_stop;
    sh_step_nx  = sh_step;
    sh_dwell_nx = sh_dwell;
    sh_phase_nx = sh_phase;
    sh_loop_nx  = sh_loop;
    sh_tri_nx   = sh_tri;
    if (accept) begin
      sh_start_nx = cfg_start;
      sh_stop_nx  = cfg_stop;
      sh_step_nx  = cfg_step;
      sh_dwell_nx = cfg_dwell;
      sh_phase_nx = cfg_phase;
      sh_loop_nx  = cfg_loop;
`ifdef NCO_SWEEP_TRI_EN
      sh_tri_nx   = cfg_tri;
`endif
    end
    case (state)
      S_IDLE: begin
        if (go && !abort) begin
          state_nx    = S_RUN;
          freq_nx     = accept ? cfg_start : sh_start;
          phase_nx    = accept ? cfg_phase : sh_phase;
          cnt_nx      = accept ? cfg_dwell : sh_dwell;
          leg_back_nx = 1'b0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_nx = S_IDLE;
        end else if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else if (freq_word == target) begin
          cnt_nx = sh_dwell;
          if (tri_eff && !leg_back) begin
            leg_back_nx = 1'b1;
            freq_nx     = step_toward(freq_word, sh_start, sh_step, !fwd_up);
          end else if (sh_loop && tri_eff) begin
            leg_back_nx = 1'b0;
            freq_nx     = step_toward(freq_word, sh_stop, sh_step, fwd_up);
          end else if (sh_loop) begin
            freq_nx = sh_start;
          end else begin
            state_nx = S_DONE;
          end
        end else begin
          cnt_nx  = sh_dwell;
          freq_nx = step_toward(freq_word, target, sh_step, leg_back ? !fwd_up : fwd_up);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      freq_word <= '0;
      phase_off <= '0;
      cnt       <= '0;
      leg_back  <= 1'b0;
      sh_start  <= '0;
      sh_stop   <= '0;
      sh_step   <= '0;
      sh_dwell  <= '0;
      sh_phase  <= '0;
      sh_loop   <= 1'b0;
    end else begin
      state     <= state_nx;
      freq_word <= freq_nx;
      phase_off <= phase_nx;
      cnt       <= cnt_nx;
      leg_back  <= leg_back_nx;
      sh_start  <= sh_start_nx;
      sh_stop   <= sh_stop_nx;
      sh_step   <= sh_step_nx;
      sh_dwell  <= sh_dwell_nx;
      sh_phase  <= sh_phase_nx;
      sh_loop   <= sh_loop_nx;
    end
  end

`ifdef NCO_SWEEP_TRI_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh_tri <= 1'b0;
    else        sh_tri <= sh_tri_nx;
  end
`else
  assign sh_tri = 1'b0;
`endif

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed testbench for nco_sweep_ctrl; samples and drives on the falling clock edge.
module tb_nco_sweep_ctrl;
  localparam int FW = 10;
  localparam int PW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n, cfg_valid, cfg_ready, cfg_loop, go, abort;
  logic [FW-1:0] cfg_start, cfg_stop, cfg_step, freq_word;
  logic [DW-1:0] cfg_dwell;
  logic [PW-1:0] cfg_phase, phase_off;
  logic          nco_en, busy, done;
`ifdef NCO_SWEEP_TRI_EN
  logic          cfg_tri;
`endif

  int passed = 0;
  int total  = 0;
  logic [FW-1:0] exp_q[$];

  always #5 clk = ~clk;

  nco_sweep_ctrl #(.FW(FW), .PW(PW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_step(cfg_step),
    .cfg_dwell(cfg_dwell), .cfg_phase(cfg_phase), .cfg_loop(cfg_loop),
`ifdef NCO_SWEEP_TRI_EN
    .cfg_tri(cfg_tri),
`endif
    .go(go), .abort(abort), .freq_word(freq_word), .phase_off(phase_off),
    .nco_en(nco_en), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic load(input int start, input int stop, input int step, input int dwell,
                      input int phase, input logic loop);
    cfg_start = FW'(start);
    cfg_stop  = FW'(stop);
    cfg_step  = FW'(step);
    cfg_dwell = DW'(dwell);
    cfg_phase = PW'(phase);
    cfg_loop  = loop;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  // Expects exp_q frequencies one per cycle, then the done pulse, then IDLE.
  task automatic run_sweep(input string tag, input int phase);
    logic [FW-1:0] last;
    last = '0;
    foreach (exp_q[i]) begin
      check({tag, "_freq"}, 32'(freq_word), 32'(exp_q[i]));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_nodone"}, 32'(done), 32'd0);
      last = exp_q[i];
      @(negedge clk);
    end
    check({tag, "_phase"}, 32'(phase_off), 32'(phase));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_done_busy"}, 32'(busy), 32'd0);
    check({tag, "_done_en"}, 32'(nco_en), 32'd0);
    check({tag, "_done_rdy"}, 32'(cfg_ready), 32'd0);
    @(negedge clk);
    check({tag, "_post_done"}, 32'(done), 32'd0);
    check({tag, "_post_rdy"}, 32'(cfg_ready), 32'd1);
    check({tag, "_hold_freq"}, 32'(freq_word), 32'(last));
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; go = 1'b0; abort = 1'b0; cfg_loop = 1'b0;
    cfg_start = '0; cfg_stop = '0; cfg_step = '0; cfg_dwell = '0; cfg_phase = '0;
`ifdef NCO_SWEEP_TRI_EN
    cfg_tri = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_freq", 32'(freq_word), 32'd0);
    check("rst_phase", 32'(phase_off), 32'd0);
    check("rst_en", 32'(nco_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdy", 32'(cfg_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Up sweep with dwell 1
    load(256, 260, 2, 1, 8'h5A, 1'b0);
    pulse_go();
    exp_q = '{10'd256, 10'd256, 10'd258, 10'd258, 10'd260, 10'd260};
    run_sweep("up", 8'h5A);

    // Down sweep clamps at stop
    load(10, 3, 4, 0, 0, 1'b0);
    pulse_go();
    exp_q = '{10'd10, 10'd6, 10'd3};
    run_sweep("down", 0);

    // Top of range clamps without wrapping
    load(1020, 1023, 8, 0, 1, 1'b0);
    pulse_go();
    exp_q = '{10'd1020, 10'd1023};
    run_sweep("nowrap", 1);

    // Zero step jumps straight to stop
    load(100, 110, 0, 0, 2, 1'b0);
    pulse_go();
    exp_q = '{10'd100, 10'd110};
    run_sweep("step0", 2);

    // start == stop gives a single dwell
    load(50, 50, 3, 2, 3, 1'b0);
    pulse_go();
    exp_q = '{10'd50, 10'd50, 10'd50};
    run_sweep("single", 3);

    // Abort mid-dwell
    load(0, 1000, 1, 3, 0, 1'b0);
    pulse_go();
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_en", 32'(nco_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rdy", 32'(cfg_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("abort_nodone", 32'(done), 32'd0);
      @(negedge clk);
    end

    // Abort in the same cycle the final dwell expires
    load(7, 7, 1, 0, 0, 1'b0);
    pulse_go();
    check("abx_freq", 32'(freq_word), 32'd7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abx_nodone", 32'(done), 32'd0);
    check("abx_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("abx_nodone2", 32'(done), 32'd0);

    // go together with abort in IDLE is ignored
    go = 1'b1; abort = 1'b1;
    @(negedge clk);
    go = 1'b0; abort = 1'b0;
    check("goab_busy", 32'(busy), 32'd0);
    check("goab_rdy", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    check("goab_busy2", 32'(busy), 32'd0);

    // Config handshake and go in the same cycle use the new values
    cfg_start = 10'd333; cfg_stop = 10'd340; cfg_step = 10'd7; cfg_dwell = '0;
    cfg_phase = 8'h11; cfg_loop = 1'b0;
    cfg_valid = 1'b1; go = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; go = 1'b0;
    exp_q = '{10'd333, 10'd340};
    run_sweep("cfggo", 8'h11);

    // Looping sweep never completes
    load(5, 7, 1, 0, 0, 1'b1);
    pulse_go();
    for (int i = 0; i < 9; i++) begin
      check("loop_freq", 32'(freq_word), 32'(5 + (i % 3)));
      check("loop_rdy", 32'(cfg_ready), 32'd0);
      check("loop_nodone", 32'(done), 32'd0);
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("loop_exit_busy", 32'(busy), 32'd0);
    check("loop_exit_done", 32'(done), 32'd0);

    // Asynchronous reset mid-sweep takes effect immediately
    load(500, 1000, 1, 5, 8'h33, 1'b0);
    pulse_go();
    @(negedge clk);
    check("mrst_pre_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_en", 32'(nco_en), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_freq", 32'(freq_word), 32'd0);
    check("mrst_phase", 32'(phase_off), 32'd0);
    check("mrst_rdy", 32'(cfg_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_idle", 32'(busy), 32'd0);

`ifdef NCO_SWEEP_TRI_EN
    // Triangle sweep: out to stop and back to start
    cfg_tri = 1'b1;
    load(0, 4, 2, 0, 0, 1'b0);
    pulse_go();
    exp_q = '{10'd0, 10'd2, 10'd4, 10'd2, 10'd0};
    run_sweep("tri", 0);
    cfg_tri = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
